// File: rtl/lift_ctrl_if.sv
// Bus between the four-floor lift controller and its hall-call latch / car hardware.
// Signal names follow the block's published pin list.
interface lift_ctrl_if;
    logic [5:0] get_call;
    logic [1:0] cur_Floor;
    logic       ce;
    logic       moving;
    logic       dir_up;
    logic       arrive;

    modport master (
        output get_call,
        input  cur_Floor, ce, moving, dir_up, arrive
    );

    modport slave (
        input  get_call,
        output cur_Floor, ce, moving, dir_up, arrive
    );
endinterface

// File: rtl/lift_ctrl.sv
// Four-floor single-car lift controller: sweep scheduling, timed travel per floor and
// a timed door phase whose ce output tells the call latch to clear the current floor.
module lift_ctrl #(
    parameter int unsigned TRAVEL_CYC = 8,
    parameter int unsigned DOOR_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst,
    lift_ctrl_if.slave  lift_io
);

    typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDown, StDoor} state_e;

    localparam logic [7:0] LastTravel = 8'(TRAVEL_CYC - 1);
    localparam logic [7:0] LastDoor   = 8'(DOOR_CYC - 1);

    state_e     state_q, state_d;
    logic [1:0] floor_q, floor_d;
    logic [7:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic       arrive_q, arrive_d;

    // Per-floor call summary and sweep masks relative to the current and adjacent floors.
    logic [3:0] at_v;
    logic [1:0] floor_up, floor_dn;
    logic [3:0] mask_above_cur, mask_below_cur, mask_above_up, mask_below_dn;
    logic       at_cur, above_cur, below_cur, at_up, at_dn, above_up, below_dn;

    always_comb begin
        at_v           = {lift_io.get_call[5],
                          lift_io.get_call[4] | lift_io.get_call[3],
                          lift_io.get_call[2] | lift_io.get_call[1],
                          lift_io.get_call[0]};
        floor_up       = floor_q + 2'd1;
        floor_dn       = floor_q - 2'd1;
        mask_above_cur = 4'b1110 << floor_q;
        mask_below_cur = (4'b0001 << floor_q) - 4'd1;
        mask_above_up  = 4'b1110 << floor_up;
        mask_below_dn  = (4'b0001 << floor_dn) - 4'd1;
        at_cur         = at_v[floor_q];
        at_up          = at_v[floor_up];
        at_dn          = at_v[floor_dn];
        above_cur      = |(at_v & mask_above_cur);
        below_cur      = |(at_v & mask_below_cur);
        above_up       = |(at_v & mask_above_up);
        below_dn       = |(at_v & mask_below_dn);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            floor_q  <= 2'd0;
            cnt_q    <= 8'd0;
            dir_q    <= 1'b1;
            arrive_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            arrive_q <= arrive_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        arrive_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                if (at_cur) begin
                    state_d = StDoor;
                end else if (dir_q) begin
                    if (above_cur) begin
                        state_d = StMoveUp;
                    end else if (below_cur) begin
                        state_d = StMoveDown;
                        dir_d   = 1'b0;
                    end
                end else begin
                    if (below_cur) begin
                        state_d = StMoveDown;
                    end else if (above_cur) begin
                        state_d = StMoveUp;
                        dir_d   = 1'b1;
                    end
                end
            end
            StMoveUp: begin
                if (cnt_q == LastTravel) begin
                    // Arrival edge: decide from the floor being arrived at, not the old one.
                    floor_d  = floor_up;
                    arrive_d = 1'b1;
                    cnt_d    = 8'd0;
                    if (at_up) begin
                        state_d = StDoor;
                    end else if (!above_up) begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StMoveDown: begin
                if (cnt_q == LastTravel) begin
                    floor_d  = floor_dn;
                    arrive_d = 1'b1;
                    cnt_d    = 8'd0;
                    if (at_dn) begin
                        state_d = StDoor;
                    end else if (!below_dn) begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDoor: begin
                if (cnt_q == LastDoor) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        lift_io.cur_Floor = floor_q;
        lift_io.ce        = (state_q == StDoor);
        lift_io.moving    = (state_q == StMoveUp) || (state_q == StMoveDown);
        lift_io.dir_up    = dir_q;
        lift_io.arrive    = arrive_q;
    end

endmodule

// File: tb/tb_lift_ctrl.sv
// Randomized and directed bench for lift_ctrl against a floor/timer reference model;
// the bench also plays the role of the hall-call latch, clearing a floor while ce is high.
module tb_lift_ctrl;

    localparam int TRAVEL = 8;
    localparam int DOOR   = 4;
    localparam int MIdle  = 0;
    localparam int MUp    = 1;
    localparam int MDown  = 2;
    localparam int MDoor  = 3;

    logic clk;
    logic rst;
    lift_ctrl_if bus ();

    lift_ctrl #(
        .TRAVEL_CYC (TRAVEL),
        .DOOR_CYC   (DOOR)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .lift_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [5:0] calls;

    int m_mode, m_floor, m_left;
    bit m_dir, m_arrive;

    int door_cyc [4];
    int door_order [$];
    bit prev_ce;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 30) $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] floor_mask(input int f);
        case (f)
            0:       return 6'b000001;
            1:       return 6'b000110;
            2:       return 6'b011000;
            default: return 6'b100000;
        endcase
    endfunction

    function automatic bit has_call(input logic [5:0] c, input int f);
        return |(c & floor_mask(f));
    endfunction

    function automatic bit any_above(input logic [5:0] c, input int f);
        for (int g = f + 1; g < 4; g++) if (has_call(c, g)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(input logic [5:0] c, input int f);
        for (int g = 0; g < f; g++) if (has_call(c, g)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode = MIdle; m_floor = 0; m_left = 0; m_dir = 1'b1; m_arrive = 1'b0;
    endtask

    // One clock edge of the reference: a remaining-cycles timer per travel/door phase.
    task automatic model_step(input logic [5:0] c);
        m_arrive = 1'b0;
        case (m_mode)
            MIdle: begin
                if (has_call(c, m_floor)) begin
                    m_mode = MDoor; m_left = DOOR;
                end else if (m_dir) begin
                    if (any_above(c, m_floor)) begin m_mode = MUp; m_left = TRAVEL; end
                    else if (any_below(c, m_floor)) begin
                        m_mode = MDown; m_left = TRAVEL; m_dir = 1'b0;
                    end
                end else begin
                    if (any_below(c, m_floor)) begin m_mode = MDown; m_left = TRAVEL; end
                    else if (any_above(c, m_floor)) begin
                        m_mode = MUp; m_left = TRAVEL; m_dir = 1'b1;
                    end
                end
            end
            MUp, MDown: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor  = m_floor + ((m_mode == MUp) ? 1 : -1);
                    m_arrive = 1'b1;
                    if (has_call(c, m_floor)) begin
                        m_mode = MDoor; m_left = DOOR;
                    end else if ((m_mode == MUp) ? any_above(c, m_floor)
                                                 : any_below(c, m_floor)) begin
                        m_left = TRAVEL;
                    end else begin
                        m_mode = MIdle;
                    end
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_mode = MIdle;
            end
        endcase
    endtask

    task automatic clear_stats();
        for (int f = 0; f < 4; f++) door_cyc[f] = 0;
        door_order.delete();
        prev_ce = 1'b0;
    endtask

    task automatic tick(input bit rnd);
        @(posedge clk);
        if (!rst) model_step(calls);
        #1;
        check_eq("cur_Floor", 32'(bus.cur_Floor), 32'(m_floor));
        check_eq("ce", 32'(bus.ce), 32'(m_mode == MDoor));
        check_eq("moving", 32'(bus.moving), 32'((m_mode == MUp) || (m_mode == MDown)));
        check_eq("dir_up", 32'(bus.dir_up), 32'(m_dir));
        check_eq("arrive", 32'(bus.arrive), 32'(m_arrive));
        if (bus.ce === 1'b1) begin
            door_cyc[bus.cur_Floor]++;
            if (!prev_ce) door_order.push_back(int'(bus.cur_Floor));
        end
        prev_ce = (bus.ce === 1'b1);
        if (rnd && $urandom_range(0, 7) == 0) calls = calls | 6'(1 << $urandom_range(0, 5));
        if (m_mode == MDoor) calls = calls & ~floor_mask(m_floor);
        bus.get_call = calls;
    endtask

    task automatic pulse_reset(input int hold);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check_eq("async_rst_floor", 32'(bus.cur_Floor), 32'd0);
        check_eq("async_rst_ce", 32'(bus.ce), 32'd0);
        check_eq("async_rst_moving", 32'(bus.moving), 32'd0);
        check_eq("async_rst_dir", 32'(bus.dir_up), 32'd1);
        check_eq("async_rst_arrive", 32'(bus.arrive), 32'd0);
        repeat (hold) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic set_calls(input logic [5:0] c);
        calls = c;
        bus.get_call = calls;
    endtask

    task automatic run_idle(input string tag, input int budget);
        int i;
        i = 0;
        while (i < budget && !(m_mode == MIdle && calls == 6'd0)) begin
            tick(1'b0);
            i++;
        end
        check_eq(tag, 32'(m_mode == MIdle && calls == 6'd0), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        set_calls(6'd0);
        model_reset();
        clear_stats();
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Quiet reset release: everything holds for 50 cycles.
        for (int i = 0; i < 50; i++) tick(1'b0);

        // F3 down call from F0: three segments up, door at F3.
        set_calls(6'b100000);
        clear_stats();
        run_idle("f3_run_done", 200);
        check_eq("f3_door_cycles", 32'(door_cyc[3]), 32'(DOOR));

        // Call at the current floor opens the door without moving.
        pulse_reset(2);
        set_calls(6'b000001);
        clear_stats();
        run_idle("f0_door_done", 50);
        check_eq("f0_door_cycles", 32'(door_cyc[0]), 32'(DOOR));

        // Park at F1 heading up, then calls at both ends: up-sweep serves F3 first.
        pulse_reset(2);
        set_calls(6'b000010);
        run_idle("park_f1", 100);
        set_calls(6'b100001);
        clear_stats();
        run_idle("sweep_done", 300);
        check_eq("sweep_n_doors", 32'(door_order.size()), 32'd2);
        if (door_order.size() == 2) begin
            check_eq("sweep_first", 32'(door_order[0]), 32'd3);
            check_eq("sweep_second", 32'(door_order[1]), 32'd0);
        end

        // Call at F2 added 3 cycles into the F1->F2 segment: stop at F2 on the way to F3.
        pulse_reset(2);
        set_calls(6'b100000);
        clear_stats();
        for (int i = 0; i < 100 && m_floor != 1; i++) tick(1'b0);
        check_eq("reach_f1", 32'(m_floor), 32'd1);
        repeat (3) tick(1'b0);
        set_calls(calls | 6'b001000);
        run_idle("midtravel_done", 300);
        check_eq("mid_f2_door", 32'(door_cyc[2]), 32'(DOOR));
        check_eq("mid_f3_door", 32'(door_cyc[3]), 32'(DOOR));
        if (door_order.size() >= 1) check_eq("mid_order", 32'(door_order[0]), 32'd2);

        // Reset in the middle of a door visit at F2.
        pulse_reset(2);
        set_calls(6'b001000);
        for (int i = 0; i < 100 && !(m_mode == MDoor && m_floor == 2); i++) tick(1'b0);
        check_eq("reach_f2_door", 32'(m_mode == MDoor && m_floor == 2), 32'd1);
        tick(1'b0);
        pulse_reset(1);
        clear_stats();
        for (int i = 0; i < 30; i++) tick(1'b0);
        check_eq("no_reopen_f2", 32'(door_cyc[2]), 32'd0);
        check_eq("rst_floor_hold", 32'(bus.cur_Floor), 32'd0);

        // Random calls with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            tick(1'b1);
            if ($urandom_range(0, 999) == 0) pulse_reset(int'($urandom_range(1, 3)));
        end
        set_calls(calls);
        run_idle("rand_drain", 400);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
